// File: rtl/reg_pipeline.sv
// Elastic DEPTH-stage register pipeline with valid/ready handshake, synchronous
// flush and a registered occupancy count.
module reg_pipeline #(
    parameter int unsigned      WIDTH       = 32,
    parameter int unsigned      DEPTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] w_valid;
    logic [WIDTH-1:0] w_data [DEPTH];
    logic [DEPTH-1:0] w_rdy;
    logic             w_in_fire;
    logic             w_out_fire;
    logic [OCC_W-1:0] r_occ;

    assign in_ready   = w_rdy[0] & ~flush;
    assign w_in_fire  = in_valid & in_ready;
    assign out_valid  = w_valid[DEPTH-1];
    assign out_data   = w_data[DEPTH-1];
    assign w_out_fire = out_valid & out_ready;
    assign occupancy  = r_occ;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic             r_v;
        logic [WIDTH-1:0] r_d;
        logic             w_up_valid;
        logic [WIDTH-1:0] w_up_data;

        // A stage may load when any stage from here to the output is empty,
        // or the consumer is taking the head item.
        assign w_rdy[g] = out_ready | ~(&w_valid[DEPTH-1:g]);

        if (g == 0) begin : g_head
            assign w_up_valid = in_valid;
            assign w_up_data  = in_data;
        end else begin : g_body
            assign w_up_valid = w_valid[g-1];
            assign w_up_data  = w_data[g-1];
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_v <= 1'b0;
                r_d <= RESET_VALUE;
            end else if (flush) begin
                r_v <= 1'b0;
            end else if (w_rdy[g]) begin
                r_v <= w_up_valid;
                if (w_up_valid) begin
                    r_d <= w_up_data;
                end
            end
        end

        assign w_valid[g] = r_v;
        assign w_data[g]  = r_d;
    end

    // Occupancy tracks accepted minus delivered items; flush empties it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_occ <= '0;
        end else if (flush) begin
            r_occ <= '0;
        end else begin
            case ({w_in_fire, w_out_fire})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule
